// File: rtl/axi_ic_pkg.sv
// ----------------------------------------------------------------------------
// axi_ic_pkg
// Shared definitions for the AXI interconnect read path.
//   mw_f / tw_f / iw_f : width helpers for master-id, transaction-id and
//                        slave-side RID fields (never narrower than 1 bit).
//   rresp_e            : AXI read response encodings.
// ----------------------------------------------------------------------------
package axi_ic_pkg;

    // $clog2(1) is 0; clamp to 1 so degenerate configurations still yield
    // legal vector widths.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned mw_f(input int unsigned num_masters);
        return clog2_min1(num_masters);
    endfunction

    function automatic int unsigned tw_f(input int unsigned num_outstanding);
        return clog2_min1(num_outstanding);
    endfunction

    function automatic int unsigned iw_f(input int unsigned num_masters,
                                         input int unsigned num_outstanding);
        return mw_f(num_masters) + tw_f(num_outstanding);
    endfunction

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } rresp_e;

endpackage

// File: rtl/read_data_router_if.sv
// ----------------------------------------------------------------------------
// read_data_router_if
// Bundles the slave-side R channel, arbiter handshake and master-side R
// channel of the read data router.
//   modport slave  : router view (consumes slave beats and arbiter decisions,
//                    produces master beats and arbiter requests).
//   modport master : environment view (slaves, arbiter and masters).
// Signals (flattened, index 0 in the LSBs):
//   s_rvalid_f/s_rid_f/s_rdata_f/s_rresp_f/s_rlast_f/s_rready_f  slave R
//   R_request_f/R_id_f/R_last_f/R_grant_f/R_sel_f                arbiter
//   m_rvalid_f/m_rid_f/m_rdata_f/m_rresp_f/m_rlast_f/m_rready_f  master R
// ----------------------------------------------------------------------------
interface read_data_router_if
    import axi_ic_pkg::*;
#(
    parameter int unsigned M                     = 2,
    parameter int unsigned S                     = 2,
    parameter int unsigned NUM_OUTSTANDING_TRANS = 2,
    parameter int unsigned DATA_WIDTH            = 32
);

    localparam int unsigned MW = mw_f(M);
    localparam int unsigned TW = tw_f(NUM_OUTSTANDING_TRANS);
    localparam int unsigned IW = MW + TW;

    // Slave-side R channel
    logic [S-1:0]            s_rvalid_f;
    logic [S*IW-1:0]         s_rid_f;
    logic [S*DATA_WIDTH-1:0] s_rdata_f;
    logic [S*2-1:0]          s_rresp_f;
    logic [S-1:0]            s_rlast_f;
    logic [S-1:0]            s_rready_f;

    // Arbiter handshake
    logic [S-1:0]            R_request_f;
    logic [S*IW-1:0]         R_id_f;
    logic [S-1:0]            R_last_f;
    logic [S-1:0]            R_grant_f;
    logic [S*MW-1:0]         R_sel_f;

    // Master-side R channel
    logic [M-1:0]            m_rvalid_f;
    logic [M*TW-1:0]         m_rid_f;
    logic [M*DATA_WIDTH-1:0] m_rdata_f;
    logic [M*2-1:0]          m_rresp_f;
    logic [M-1:0]            m_rlast_f;
    logic [M-1:0]            m_rready_f;

    modport slave (
        input  s_rvalid_f, s_rid_f, s_rdata_f, s_rresp_f, s_rlast_f,
        output s_rready_f,
        output R_request_f, R_id_f, R_last_f,
        input  R_grant_f, R_sel_f,
        output m_rvalid_f, m_rid_f, m_rdata_f, m_rresp_f, m_rlast_f,
        input  m_rready_f
    );

    modport master (
        output s_rvalid_f, s_rid_f, s_rdata_f, s_rresp_f, s_rlast_f,
        input  s_rready_f,
        input  R_request_f, R_id_f, R_last_f,
        output R_grant_f, R_sel_f,
        input  m_rvalid_f, m_rid_f, m_rdata_f, m_rresp_f, m_rlast_f,
        output m_rready_f
    );

endinterface

// File: rtl/read_data_router_slice.sv
// ----------------------------------------------------------------------------
// rd_slice
// One-entry valid/ready pipeline register for a master R output.
// Each edge: load when load_i, else drain when rready_i, else hold.
// Load and drain in the same cycle replaces the entry with no bubble.
// Ports:
//   clk_i, clr_i   clock, synchronous active-high reset
//   load_i, data_i new beat accepted upstream this cycle and its payload
//   rready_i       downstream ready
//   valid_o,data_o registered beat presented downstream
// ----------------------------------------------------------------------------
module rd_slice #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         rready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (rready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/read_data_router.sv
// ----------------------------------------------------------------------------
// read_data_router
// R channel datapath downstream of the read arbiter. Forwards per-slave
// requests/IDs/last-beat events to the arbiter and steers granted slave
// beats into a one-entry register per master.
// Ports:
//   clk     clock (rising edge)
//   clr     synchronous active-high reset
//   bus     read_data_router_if.slave: slave R, arbiter and master R signals
//   id_err  sticky flag: an accepted beat's RID master field differed from
//           the arbiter's select for that slave
// ----------------------------------------------------------------------------
module read_data_router
    import axi_ic_pkg::*;
#(
    parameter int unsigned M                     = 2,
    parameter int unsigned S                     = 2,
    parameter int unsigned NUM_OUTSTANDING_TRANS = 2,
    parameter int unsigned DATA_WIDTH            = 32
) (
    input  logic                clk,
    input  logic                clr,
    read_data_router_if.slave   bus,
    output logic                id_err
);

    localparam int unsigned MW = mw_f(M);
    localparam int unsigned TW = tw_f(NUM_OUTSTANDING_TRANS);
    localparam int unsigned IW = MW + TW;
    // Slice payload: {trans_id, data, resp, last}
    localparam int unsigned PW = TW + DATA_WIDTH + 2 + 1;

    // Unflattened slave-side views
    logic [MW-1:0]         sel    [S];
    logic [IW-1:0]         rid    [S];
    logic [DATA_WIDTH-1:0] rdata  [S];
    logic [1:0]            rresp  [S];

    logic [S-1:0] win;
    logic [S-1:0] in_range;
    logic [S-1:0] rready;
    logic [S-1:0] accept;
    logic [S-1:0] mismatch;

    logic [M-1:0] slice_free;
    logic [M-1:0] load;
    logic [PW-1:0] load_data  [M];
    logic          slice_valid[M];
    logic [PW-1:0] slice_data [M];

    logic id_err_q, id_err_d;

    always_comb begin
        for (int unsigned s = 0; s < S; s++) begin
            sel[s]   = bus.R_sel_f[s*MW +: MW];
            rid[s]   = bus.s_rid_f[s*IW +: IW];
            rdata[s] = bus.s_rdata_f[s*DATA_WIDTH +: DATA_WIDTH];
            rresp[s] = bus.s_rresp_f[s*2 +: 2];
        end
    end

    always_comb begin
        for (int unsigned m = 0; m < M; m++) begin
            slice_free[m] = ~slice_valid[m] | bus.m_rready_f[m];
        end
    end

    // Ready/accept per slave. A lower-index granted slave targeting the same
    // master blocks higher ones regardless of its valid, so at most one
    // slave can load any given slice per cycle.
    always_comb begin
        win      = '1;
        in_range = '0;
        rready   = '0;
        accept   = '0;
        mismatch = '0;
        for (int unsigned s = 0; s < S; s++) begin
            for (int unsigned j = 0; j < s; j++) begin
                if (bus.R_grant_f[j] && (sel[j] == sel[s])) begin
                    win[s] = 1'b0;
                end
            end
            in_range[s] = (32'(sel[s]) < M);
            rready[s]   = bus.R_grant_f[s] & in_range[s] & win[s] &
                          (in_range[s] ? slice_free[sel[s]] : 1'b0);
            accept[s]   = bus.s_rvalid_f[s] & rready[s];
            mismatch[s] = (rid[s][IW-1:TW] != sel[s]);
        end
    end

    // Steering mux: route the accepted beat of the winning slave to its
    // selected master's slice.
    always_comb begin
        for (int unsigned m = 0; m < M; m++) begin
            load[m]      = 1'b0;
            load_data[m] = '0;
            for (int unsigned s = 0; s < S; s++) begin
                if (accept[s] && (32'(sel[s]) == m)) begin
                    load[m]      = 1'b1;
                    load_data[m] = {rid[s][TW-1:0], rdata[s], rresp[s],
                                    bus.s_rlast_f[s]};
                end
            end
        end
    end

    for (genvar g = 0; g < M; g++) begin : g_slice
        rd_slice #(
            .W(PW)
        ) u_slice (
            .clk_i   (clk),
            .clr_i   (clr),
            .load_i  (load[g]),
            .data_i  (load_data[g]),
            .rready_i(bus.m_rready_f[g]),
            .valid_o (slice_valid[g]),
            .data_o  (slice_data[g])
        );
    end

    always_comb begin
        bus.m_rvalid_f = '0;
        bus.m_rid_f    = '0;
        bus.m_rdata_f  = '0;
        bus.m_rresp_f  = '0;
        bus.m_rlast_f  = '0;
        for (int unsigned m = 0; m < M; m++) begin
            bus.m_rvalid_f[m] = slice_valid[m];
            {bus.m_rid_f[m*TW +: TW],
             bus.m_rdata_f[m*DATA_WIDTH +: DATA_WIDTH],
             bus.m_rresp_f[m*2 +: 2],
             bus.m_rlast_f[m]} = slice_data[m];
        end
    end

    assign bus.s_rready_f  = rready;
    assign bus.R_request_f = bus.s_rvalid_f;
    assign bus.R_id_f      = bus.s_rid_f;
    assign bus.R_last_f    = accept & bus.s_rlast_f;

    assign id_err_d = id_err_q | (|(accept & mismatch));

    always_ff @(posedge clk) begin
        if (clr) begin
            id_err_q <= 1'b0;
        end else begin
            id_err_q <= id_err_d;
        end
    end

    assign id_err = id_err_q;

endmodule

// File: tb/tb_read_data_router.sv
// ----------------------------------------------------------------------------
// tb_read_data_router
// Directed scoreboard bench for read_data_router (M=2, S=2, 2 outstanding,
// 32-bit data). Stimulus pushes the expected master beat when a slave beat
// is offered; a negedge monitor compares every presented master beat against
// the head of that master's queue and pops it on handshake.
// ----------------------------------------------------------------------------
module tb_read_data_router;
    import axi_ic_pkg::*;

    typedef struct packed {
        logic        tid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic id_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    beat_t q0[$];
    beat_t q1[$];

    read_data_router_if #(
        .M(2), .S(2), .NUM_OUTSTANDING_TRANS(2), .DATA_WIDTH(32)
    ) bus ();

    read_data_router #(
        .M(2), .S(2), .NUM_OUTSTANDING_TRANS(2), .DATA_WIDTH(32)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .bus   (bus),
        .id_err(id_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int m, input beat_t b);
        if (m == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // Monitor: every presented master beat must match the queue head.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (bus.m_rvalid_f[m]) begin
                beat_t got;
                int    qs;
                got = {bus.m_rid_f[m], bus.m_rdata_f[m*32 +: 32],
                       bus.m_rresp_f[m*2 +: 2], bus.m_rlast_f[m]};
                qs  = (m == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    vec_cnt++;
                    miss_cnt++;
                    $display("FAIL m%0d unexpected beat: got %0h expected none (t=%0t)",
                             m, got, $time);
                end else begin
                    chk($sformatf("m%0d beat", m), 64'(got),
                        64'((m == 0) ? q0[0] : q1[0]));
                    if (bus.m_rready_f[m]) begin
                        if (m == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    // Offer one beat on slave s, wait (bounded) for its handshake, then check
    // the last-beat pulse and one-cycle delivery latency. Returns at posedge+1
    // with valid still asserted so the next beat follows back-to-back.
    task automatic send_beat(input int s, input logic [1:0] rid,
                             input logic [31:0] data, input logic [1:0] resp,
                             input logic last, input int exp_m);
        logic got_rdy;
        bus.s_rvalid_f[s]        = 1'b1;
        bus.s_rid_f[s*2 +: 2]    = rid;
        bus.s_rdata_f[s*32 +: 32] = data;
        bus.s_rresp_f[s*2 +: 2]  = resp;
        bus.s_rlast_f[s]         = last;
        push_exp(exp_m, {rid[0], data, resp, last});
        got_rdy = 1'b0;
        for (int i = 0; i < 30 && !got_rdy; i++) begin
            @(negedge clk);
            got_rdy = bus.s_rready_f[s];
        end
        chk($sformatf("s%0d handshake", s), 64'(got_rdy), 64'(1));
        if (got_rdy) begin
            chk($sformatf("R_last s%0d", s), 64'(bus.R_last_f[s]), 64'(last));
            @(posedge clk);
            #1;
            chk($sformatf("m%0d rvalid latency", exp_m),
                64'(bus.m_rvalid_f[exp_m]), 64'(1));
        end
    endtask

    task automatic drop_valid(input int s);
        bus.s_rvalid_f[s] = 1'b0;
        bus.s_rlast_f[s]  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_rvalid_f = '0;
        bus.s_rid_f    = '0;
        bus.s_rdata_f  = '0;
        bus.s_rresp_f  = '0;
        bus.s_rlast_f  = '0;
        bus.R_grant_f  = '0;
        bus.R_sel_f    = '0;
        bus.m_rready_f = '0;

        // ---- reset state
        cycles(2);
        clr = 1'b0;
        chk("reset m_rvalid", 64'(bus.m_rvalid_f), 64'(0));
        chk("reset m_rid",    64'(bus.m_rid_f),    64'(0));
        chk("reset m_rdata",  64'(bus.m_rdata_f),  64'(0));
        chk("reset m_rresp",  64'(bus.m_rresp_f),  64'(0));
        chk("reset m_rlast",  64'(bus.m_rlast_f),  64'(0));
        chk("reset id_err",   64'(id_err),         64'(0));
        chk("reset s_rready", 64'(bus.s_rready_f), 64'(0));

        // ---- single burst: slave1 -> master1, RID {1,1}, 4 beats
        bus.R_grant_f  = 2'b10;
        bus.R_sel_f    = 2'b10;
        bus.m_rready_f = 2'b11;
        for (int b = 0; b < 4; b++)
            send_beat(1, 2'b11, 32'hA000_0001 + b, OKAY, b == 3, 1);
        drop_valid(1);
        cycles(2);
        chk("burst id_err", 64'(id_err), 64'(0));

        // ---- backpressure: slave0 -> master0, ready0 low 3 cycles mid-burst
        bus.R_grant_f = 2'b01;
        fork
            begin
                for (int b = 0; b < 6; b++)
                    send_beat(0, 2'b00, 32'hB000_0000 + b,
                              (b == 3) ? SLVERR : EXOKAY, b == 5, 0);
                drop_valid(0);
            end
            begin
                cycles(2);
                bus.m_rready_f[0] = 1'b0;
                @(negedge clk);
                chk("bp s_rready0", 64'(bus.s_rready_f[0]), 64'(0));
                chk("bp m_rvalid0", 64'(bus.m_rvalid_f[0]), 64'(1));
                cycles(3);
                bus.m_rready_f[0] = 1'b1;
            end
        join
        cycles(3);

        // ---- conflict: both granted to master 0, lowest index wins
        bus.R_grant_f = 2'b11;
        bus.R_sel_f   = 2'b00;
        bus.s_rvalid_f[1]      = 1'b1;
        bus.s_rid_f[3:2]       = 2'b01;
        bus.s_rdata_f[63:32]   = 32'hC100_0000;
        bus.s_rresp_f[3:2]     = OKAY;
        bus.s_rlast_f[1]       = 1'b0;
        @(negedge clk);
        chk("conflict s_rready", 64'(bus.s_rready_f), 64'(2'b01));
        cycles(1);
        send_beat(0, 2'b00, 32'hC000_0000, OKAY, 1'b0, 0);
        send_beat(0, 2'b00, 32'hC000_0001, OKAY, 1'b1, 0);
        drop_valid(0);
        @(negedge clk);
        chk("conflict s_rready1 held", 64'(bus.s_rready_f[1]), 64'(0));
        cycles(1);
        bus.R_grant_f = 2'b10;
        send_beat(1, 2'b01, 32'hC100_0000, OKAY, 1'b0, 0);
        send_beat(1, 2'b01, 32'hC100_0001, EXOKAY, 1'b1, 0);
        drop_valid(1);
        cycles(3);

        // ---- ID mismatch: slave0 RID master field 1, sel 0
        bus.R_grant_f = 2'b01;
        bus.R_sel_f   = 2'b10;
        @(negedge clk);
        chk("pre-mismatch id_err", 64'(id_err), 64'(0));
        cycles(1);
        send_beat(0, 2'b10, 32'hD000_0000, DECERR, 1'b1, 0);
        chk("mismatch id_err", 64'(id_err), 64'(1));
        drop_valid(0);
        cycles(3);
        chk("mismatch id_err sticky", 64'(id_err), 64'(1));
        chk("mismatch m_rvalid idle", 64'(bus.m_rvalid_f), 64'(0));

        // ---- reset with both slices full
        bus.m_rready_f = 2'b00;
        bus.R_grant_f  = 2'b11;
        bus.R_sel_f    = 2'b10;
        push_exp(0, {1'b0, 32'hE000_0000, 2'b00, 1'b1});
        push_exp(1, {1'b1, 32'hE100_0000, 2'b00, 1'b0});
        bus.s_rvalid_f      = 2'b11;
        bus.s_rid_f         = 4'b1100;
        bus.s_rdata_f       = {32'hE100_0000, 32'hE000_0000};
        bus.s_rresp_f       = 4'b0000;
        bus.s_rlast_f       = 2'b01;
        @(negedge clk);
        chk("fill s_rready", 64'(bus.s_rready_f), 64'(2'b11));
        cycles(1);
        drop_valid(0);
        drop_valid(1);
        chk("fill m_rvalid", 64'(bus.m_rvalid_f), 64'(2'b11));
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        q0.delete();
        q1.delete();
        chk("clr m_rvalid",  64'(bus.m_rvalid_f), 64'(0));
        chk("clr id_err",    64'(id_err),         64'(0));
        chk("clr m_rdata",   64'(bus.m_rdata_f),  64'(0));
        chk("clr m_rid",     64'(bus.m_rid_f),    64'(0));
        chk("clr m_rlast",   64'(bus.m_rlast_f),  64'(0));
        chk("clr s_rready",  64'(bus.s_rready_f), 64'(2'b11));
        bus.m_rready_f = 2'b11;
        bus.R_grant_f  = 2'b10;
        send_beat(1, 2'b11, 32'hF000_0000, OKAY, 1'b0, 1);
        send_beat(1, 2'b11, 32'hF000_0001, OKAY, 1'b1, 1);
        drop_valid(1);
        cycles(3);

        // ---- ungranted slave
        bus.R_grant_f       = 2'b00;
        bus.s_rvalid_f[1]   = 1'b1;
        bus.s_rid_f[3:2]    = 2'b01;
        bus.s_rlast_f[1]    = 1'b1;
        @(negedge clk);
        chk("ungranted R_request", 64'(bus.R_request_f), 64'(2'b10));
        chk("ungranted R_id1",     64'(bus.R_id_f[3:2]), 64'(2'b01));
        chk("ungranted s_rready",  64'(bus.s_rready_f),  64'(0));
        chk("ungranted R_last",    64'(bus.R_last_f),    64'(0));
        repeat (3) @(negedge clk);
        chk("ungranted m_rvalid",  64'(bus.m_rvalid_f),  64'(0));
        cycles(1);
        drop_valid(1);
        cycles(3);

        chk("q0 drained", 64'(q0.size()), 64'(0));
        chk("q1 drained", 64'(q1.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
